// File: rtl/bus_target_pkg.sv
// Shared definitions for the 8080 external handshake bus: phase encodings and
// the target FSM state type.
package bus_target_pkg;

    localparam logic [1:0] BUS_ADDR_HI = 2'd0;
    localparam logic [1:0] BUS_ADDR_LO = 2'd1;
    localparam logic [1:0] BUS_WRITE   = 2'd2;
    localparam logic [1:0] BUS_READ    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StMem,
        StDrive,
        StAck
    } bus_fsm_e;

    function automatic logic is_mem_phase(input logic [1:0] phase);
        return (phase == BUS_WRITE) || (phase == BUS_READ);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with asynchronous reset to zero.
module sync_ff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[STAGES-1];

endmodule

// File: rtl/bus_target.sv
// Target-side responder for the 8080 four-phase handshake bus: assembles the
// address from two byte phases and performs reads/writes on a simple memory port.
module bus_target
    import bus_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic [1:0]  bus_state,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        bus_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    logic     w_req_sync;
    bus_fsm_e r_state;
    logic [1:0] r_phase;
    logic [7:0] r_byte;
    logic [7:0] r_addr_hi;
    logic [7:0] r_addr_lo;
    logic [7:0] r_wdata;
    logic [7:0] r_data_out;
    logic       r_we;
    logic       r_re;
    logic       r_oe;
    logic       r_ack;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus_req),
        .o_q   (w_req_sync)
    );

    // Phase and byte are captured once in IDLE; later bus activity is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_phase    <= BUS_ADDR_HI;
            r_byte     <= 8'h00;
            r_addr_hi  <= 8'h00;
            r_addr_lo  <= 8'h00;
            r_wdata    <= 8'h00;
            r_data_out <= 8'h00;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_oe       <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req_sync) begin
                        r_phase <= bus_state;
                        r_byte  <= bus_data_in;
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    if (is_mem_phase(r_phase)) begin
                        r_state <= StMem;
                        if (r_phase == BUS_WRITE) begin
                            r_wdata <= r_byte;
                            r_we    <= 1'b1;
                        end else begin
                            r_re    <= 1'b1;
                        end
                    end else begin
                        if (r_phase == BUS_ADDR_HI) begin
                            r_addr_hi <= r_byte;
                        end else begin
                            r_addr_lo <= r_byte;
                        end
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        r_we <= 1'b0;
                        r_re <= 1'b0;
                        if (r_re) begin
                            r_data_out <= mem_rdata;
                            r_oe       <= 1'b1;
                            r_state    <= StDrive;
                        end else begin
                            r_ack   <= 1'b1;
                            r_state <= StAck;
                        end
                    end
                end
                StDrive: begin
                    // One cycle of data setup on the pins before acknowledging.
                    r_ack   <= 1'b1;
                    r_state <= StAck;
                end
                StAck: begin
                    if (!w_req_sync) begin
                        r_ack   <= 1'b0;
                        r_oe    <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus_data_out = r_data_out;
    assign bus_data_oe  = r_oe;
    assign bus_ack      = r_ack;
    assign mem_addr     = {r_addr_hi, r_addr_lo};
    assign mem_wdata    = r_wdata;
    assign mem_we       = r_we;
    assign mem_re       = r_re;

endmodule

// File: tb/tb_bus_target.sv
// Directed self-checking bench for bus_target with a small ready-delay memory model.
module tb_bus_target;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic [1:0]  bus_state = 2'd0;
    logic [7:0]  bus_data_in = 8'h00;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        bus_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready;

    int n_checks = 0;
    int n_fail = 0;
    int tb_wait = 0;
    logic force_ready = 1'b0;
    int strobe_cnt = 0;

    int re_cnt;
    int we_cnt;
    int oe_ever;
    logic [15:0] strobe_addr;
    logic [7:0]  strobe_wdata;

    bus_target #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_req      (bus_req),
        .bus_state    (bus_state),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .bus_ack      (bus_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory answers after tb_wait cycles of strobe, unless forced ready.
    always @(posedge clk) begin
        if (mem_re || mem_we) strobe_cnt <= strobe_cnt + 1;
        else                  strobe_cnt <= 0;
    end
    assign mem_ready = force_ready || ((mem_re || mem_we) && (strobe_cnt >= tb_wait));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_re || mem_we) begin
            strobe_addr  = mem_addr;
            strobe_wdata = mem_wdata;
        end
        if (mem_re)      re_cnt++;
        if (mem_we)      we_cnt++;
        if (bus_data_oe) oe_ever++;
    endtask

    // One full handshake: ack expected exactly lat cycles after req rises.
    task automatic phase(input string tag, input logic [1:0] st, input logic [7:0] d,
                         input int lat, input int hold, input bit glitch, input logic exp_oe);
        re_cnt = 0; we_cnt = 0; oe_ever = 0;
        bus_state = st; bus_data_in = d; bus_req = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            tick();
            if (glitch && i == S + 2) begin
                bus_state = ~st;
                bus_data_in = ~d;
            end
            if (i == lat - 1) begin
                check({tag, "_ack_early"}, bus_ack, 1'b0);
                check({tag, "_oe_pre"}, bus_data_oe, exp_oe);
            end
        end
        check({tag, "_ack_rise"}, bus_ack, 1'b1);
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) begin
            check({tag, "_ack_hold"}, bus_ack, 1'b1);
            check({tag, "_oe_hold"}, bus_data_oe, exp_oe);
        end
        bus_req = 1'b0;
        for (int i = 0; i < S; i++) tick();
        check({tag, "_ack_late"}, bus_ack, 1'b1);
        tick();
        check({tag, "_ack_fall"}, bus_ack, 1'b0);
        check({tag, "_oe_fall"}, bus_data_oe, 1'b0);
    endtask

    initial begin
        int got_ack;

        repeat (3) tick();
        check("rst_ack", bus_ack, 1'b0);
        check("rst_oe", bus_data_oe, 1'b0);
        check("rst_dout", bus_data_out, 8'h00);
        check("rst_we", mem_we, 1'b0);
        check("rst_re", mem_re, 1'b0);
        check("rst_wdata", mem_wdata, 8'h00);
        check("rst_addr", mem_addr, 16'h0000);
        rst_n = 1'b1;
        repeat (2) tick();

        // Address then read with two ready-wait cycles.
        phase("ahi", 2'd0, 8'h12, S + 2, 0, 1'b0, 1'b0);
        phase("alo", 2'd1, 8'h34, S + 2, 0, 1'b0, 1'b0);
        check("addr_1234", mem_addr, 16'h1234);
        tb_wait = 2; mem_rdata = 8'hA5;
        phase("rd1", 2'd3, 8'h00, S + 4 + 2, 0, 1'b0, 1'b1);
        check("rd1_re_cycles", re_cnt, 3);
        check("rd1_addr", strobe_addr, 16'h1234);
        check("rd1_dout", bus_data_out, 8'hA5);

        // Write with ready tied high, including outside MEM.
        force_ready = 1'b1; tb_wait = 0;
        phase("ahi2", 2'd0, 8'h00, S + 2, 0, 1'b0, 1'b0);
        phase("alo2", 2'd1, 8'hFF, S + 2, 0, 1'b0, 1'b0);
        phase("wr1", 2'd2, 8'h5A, S + 3, 0, 1'b0, 1'b0);
        check("wr1_we_cycles", we_cnt, 1);
        check("wr1_re_cycles", re_cnt, 0);
        check("wr1_addr", strobe_addr, 16'h00FF);
        check("wr1_wdata", strobe_wdata, 8'h5A);
        check("wr1_oe_never", oe_ever, 0);
        force_ready = 1'b0;

        // Address persists with no new address phase.
        mem_rdata = 8'h3C;
        phase("rd2", 2'd3, 8'h00, S + 4, 0, 1'b0, 1'b1);
        check("rd2_addr", strobe_addr, 16'h00FF);
        check("rd2_dout", bus_data_out, 8'h3C);

        // Request held 20 cycles past ack.
        mem_rdata = 8'h96;
        phase("hold", 2'd3, 8'h00, S + 4, 20, 1'b0, 1'b1);
        check("hold_dout", bus_data_out, 8'h96);

        // Bus lines toggled during MEM must not disturb the write.
        tb_wait = 3;
        phase("glitch", 2'd2, 8'h77, S + 3 + 3, 0, 1'b1, 1'b0);
        check("glitch_we_cycles", we_cnt, 4);
        check("glitch_re_cycles", re_cnt, 0);
        check("glitch_wdata", mem_wdata, 8'h77);
        check("glitch_addr", strobe_addr, 16'h00FF);

        // Reset in the middle of a read, request held through release.
        tb_wait = 10; mem_rdata = 8'hC3;
        bus_state = 2'd3; bus_data_in = 8'h00; bus_req = 1'b1;
        repeat (S + 4) tick();
        check("mid_re_active", mem_re, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_re", mem_re, 1'b0);
        check("mid_rst_ack", bus_ack, 1'b0);
        check("mid_rst_oe", bus_data_oe, 1'b0);
        check("mid_rst_addr", mem_addr, 16'h0000);
        tb_wait = 0;
        tick();
        rst_n = 1'b1;
        re_cnt = 0;
        got_ack = 0;
        for (int i = 0; i < 20 && got_ack == 0; i++) begin
            tick();
            if (bus_ack) got_ack = 1;
        end
        check("post_rst_ack", got_ack, 1);
        check("post_rst_re_cycles", re_cnt, 1);
        check("post_rst_addr", strobe_addr, 16'h0000);
        check("post_rst_dout", bus_data_out, 8'hC3);
        bus_req = 1'b0;
        repeat (S + 1) tick();
        check("post_rst_ack_fall", bus_ack, 1'b0);
        check("post_rst_oe_fall", bus_data_oe, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_target.md
# bus_target

Target-side responder for the 8080 core's external handshake bus: it sits directly downstream of the core's bus interface, on the far side of the `req`/`ack` pins. It synchronises the incoming request and decodes the 2-bit bus phase. It assembles the 16-bit address from two byte phases, performs the read or write on a simple memory port, and returns the acknowledge, driving the data pins for reads. It is used in the FPGA companion and in the full-chip testbench as the memory/peripheral side of the system.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on the `bus_req` synchroniser; legal range is 2..3.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `bus_req` in 1: handshake request from the core; asynchronous to `clk`.
- `bus_state` in 2: phase of the current transfer.
  - 0 = ADDR_HI
  - 1 = ADDR_LO
  - 2 = WRITE
  - 3 = READ
- `bus_data_in` in 8: byte driven by the core (address or write data).
- `bus_data_out` out 8: read data returned to the core.
- `bus_data_oe` out 1: high while this block drives the data pins.
- `bus_ack` out 1: handshake acknowledge.
- `mem_addr` out 16: memory address, `{addr_hi, addr_lo}`.
- `mem_wdata` out 8: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `mem_rdata` in 8: memory read data; valid in the cycle `mem_ready` is high.
- `mem_ready` in 1: memory completion for the current strobe.

## Operation
- Handshake is four-phase level:
  1. Core sets `bus_state` and `bus_data_in`, then raises `bus_req`.
  2. Target completes the phase and raises `bus_ack`.
  3. Core drops `bus_req`.
  4. Target drops `bus_ack`.
- `bus_req` passes through the `SYNC_STAGES` synchroniser. `bus_state` and `bus_data_in` are sampled only in the IDLE cycle in which synchronised req is seen high; they are stable by protocol at that point.
- FSM states: IDLE, DECODE, MEM, DRIVE, ACK.
- IDLE -> DECODE when synchronised req = 1. `bus_state` and `bus_data_in` are captured in that transition.
- DECODE:
  - ADDR_HI: `addr_hi` <= captured byte, -> ACK.
  - ADDR_LO: `addr_lo` <= captured byte, -> ACK.
  - WRITE: `mem_wdata` <= captured byte, -> MEM with `mem_we` = 1.
  - READ: -> MEM with `mem_re` = 1.
- MEM: the strobe is held until `mem_ready` = 1.
  - Write: -> ACK.
  - Read: `bus_data_out` <= `mem_rdata`, `bus_data_oe` <= 1, -> DRIVE.
  - The strobe deasserts in the cycle after `mem_ready` is sampled.
- DRIVE: one cycle of data setup before acknowledge; -> ACK.
- ACK: `bus_ack` = 1 until synchronised req = 0. On that cycle `bus_ack` <= 0 and `bus_data_oe` <= 0 together, -> IDLE.
- `bus_data_out` holds its last value when `bus_data_oe` = 0.
- Address registers persist across transactions. There is no auto-increment; the core re-sends the address.
- A read or write issued before any address phase uses the reset address 0x0000.

## Timing
- Reset values:
  - Outputs: `bus_ack` = 0, `bus_data_oe` = 0, `bus_data_out` = 0x00, `mem_we` = 0, `mem_re` = 0, `mem_wdata` = 0x00, `mem_addr` = 0x0000.
  - FSM: IDLE.
- Latency from the `bus_req` rising edge at the synchroniser input to `bus_ack` rising (`S` = `SYNC_STAGES`, `W` = `mem_ready` wait cycles, `W` = 0 if ready on the first MEM cycle):
  - Address phase: `S`+2 cycles.
  - Write: `S`+3+`W` cycles.
  - Read: `S`+4+`W` cycles.
- Deassert: `bus_ack` falls `S`+1 cycles after `bus_req` falls.
- `bus_data_oe` is high at least one full cycle before `bus_ack` rises and falls in the same cycle as `bus_ack`.
- Changes on `bus_state` or `bus_data_in` while the FSM is outside IDLE are ignored.
- `mem_ready` outside MEM is ignored.
- `mem_addr` is stable for the whole MEM state.
- Reset asserted mid-transaction: all outputs go to reset values immediately and any strobe is abandoned.
- If `bus_req` is already high when reset releases, it is treated as a new request once synchronised.

## Structure
- The shared bus package holds:
  - Phase constants `BUS_ADDR_HI`, `BUS_ADDR_LO`, `BUS_WRITE`, `BUS_READ`.
  - The FSM state enum.
- One sub-module, `sync_ff`: a parameterised multi-stage synchroniser with reset to 0. It is reused by the core-side bus interface.

## Test plan
- Address then read: phases ADDR_HI 0x12, ADDR_LO 0x34, then READ with memory returning 0xA5 after 2 ready-wait cycles -> `mem_addr` = 0x1234, `mem_re` pulses for exactly 3 cycles, `bus_data_out` = 0xA5 with `bus_data_oe` = 1 before `bus_ack`, `bus_ack` rises at cycle 8 with `S` = 2.
- Write: ADDR_HI 0x00, ADDR_LO 0xFF, WRITE 0x5A with `mem_ready` tied high -> a single `mem_we` cycle with `mem_addr` 0x00FF and `mem_wdata` 0x5A, `bus_data_oe` never asserted.
- Address persistence: after the write above, READ with no new address phase -> `mem_addr` = 0x00FF.
- Handshake hold: keep `bus_req` high 20 cycles after ack -> `bus_ack` stays 1 and `bus_data_oe` stays 1 for a read. Drop `bus_req` -> both fall exactly `S`+1 cycles later.
- Glitch immunity: toggle `bus_state`/`bus_data_in` during MEM -> captured phase and data are unchanged.
- Reset mid-read: assert `rst_n` = 0 during MEM -> `mem_re`, `bus_ack` and `bus_data_oe` drop at once and `mem_addr` = 0x0000. Holding `bus_req` high through the reset release -> a fresh transaction completes.
